tff_updown_counter: RTL and testbench



---
 rtl/tff_counter_pkg.sv | 11 +
 rtl/tff_cell.sv | 18 +
 rtl/tff_updown_counter.sv | 115 +++++++++++
 tb/tb_tff_updown_counter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tff_counter_pkg.sv
// Shared definitions for the T flip-flop up/down counter: operating-mode encodings.
package tff_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } cnt_mode_t;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop storage cell with synchronous active-high reset.
module tff_cell (
    input  logic clock,
    input  logic reset,
    input  logic t,
    output logic q
);

    // NOTE: sequential state is always assigned with <= so every cell samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-MOD hold/up/down/load counter built from per-bit T flip-flop cells.
// Optional registered Gray-code output is enabled by defining TFF_COUNTER_GRAY_EN.
module tff_updown_counter
    import tff_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
`ifdef TFF_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] count_gray
`endif
);

    // One extra bit keeps MOD == 2**WIDTH from aliasing MOD-1 comparisons and increments.
    localparam logic [WIDTH:0] MAX_CNT = (WIDTH + 1)'(MOD - 1);
    localparam logic [WIDTH:0] ONE     = (WIDTH + 1)'(1);

    cnt_mode_t        op;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   next_ext;
    logic [WIDTH-1:0] next_cnt;
    logic [WIDTH-1:0] toggle;
    logic             wrap_next;
    logic             unused_next_msb;

    assign op       = cnt_mode_t'(mode);
    assign cnt_ext  = {1'b0, count};
    assign load_ext = {1'b0, load_val};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_ext  = cnt_ext;
        wrap_next = 1'b0;
        case (op)
            MODE_UP: begin
                if (cnt_ext > MAX_CNT) begin
                    next_ext = '0;
                end else if (cnt_ext == MAX_CNT) begin
                    if (!SATURATE) begin
                        next_ext  = '0;
                        wrap_next = 1'b1;
                    end
                end else begin
                    next_ext = cnt_ext + ONE;
                end
            end
            MODE_DOWN: begin
                if (cnt_ext > MAX_CNT) begin
                    next_ext = '0;
                end else if (cnt_ext == '0) begin
                    if (!SATURATE) begin
                        next_ext  = MAX_CNT;
                        wrap_next = 1'b1;
                    end
                end else begin
                    next_ext = cnt_ext - ONE;
                end
            end
            MODE_LOAD: begin
                next_ext = (load_ext > MAX_CNT) ? MAX_CNT : load_ext;
            end
            default: begin
                next_ext = cnt_ext;
            end
        endcase
    end

    // next never exceeds MOD-1, so its top bit is always zero.
    assign next_cnt        = next_ext[WIDTH-1:0];
    assign unused_next_msb = next_ext[WIDTH];

    // Cells only flip where the next value differs from the current one.
    assign toggle = count ^ next_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clock (clock),
            .reset (reset),
            .t     (toggle[i]),
            .q     (count[i])
        );
    end

    assign tc = ((op == MODE_UP)   && (cnt_ext == MAX_CNT)) ||
                ((op == MODE_DOWN) && (count == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

`ifdef TFF_COUNTER_GRAY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            count_gray <= '0;
        end else begin
            count_gray <= next_cnt ^ (next_cnt >> 1);
        end
    end
`endif

endmodule

// File: tb/tb_tff_updown_counter.sv
// Self-checking bench: wrapping MOD=10, saturating MOD=10 and full-range MOD=16 counters.
module tb_tff_updown_counter;
    import tff_counter_pkg::*;

    typedef struct {
        logic       r;
        logic [1:0] m;
        logic [3:0] ld;
        logic [3:0] ec;
        logic       ew;
        logic       et;
        string      tag;
    } vec_t;

    typedef struct {
        int         sel;
        logic [3:0] ec;
        logic       ew;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst  [3];
    logic [1:0] md   [3];
    logic [3:0] ld_v [3];
    logic [3:0] cnt  [3];
    logic       tc   [3];
    logic       wrp  [3];
`ifdef TFF_COUNTER_GRAY_EN
    logic [3:0] gray [3];
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) dut_w (
        .clock(clk), .reset(rst[0]), .mode(md[0]), .load_val(ld_v[0]),
        .count(cnt[0]), .tc(tc[0]), .wrap(wrp[0])
`ifdef TFF_COUNTER_GRAY_EN
        , .count_gray(gray[0])
`endif
    );

    tff_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) dut_s (
        .clock(clk), .reset(rst[1]), .mode(md[1]), .load_val(ld_v[1]),
        .count(cnt[1]), .tc(tc[1]), .wrap(wrp[1])
`ifdef TFF_COUNTER_GRAY_EN
        , .count_gray(gray[1])
`endif
    );

    tff_updown_counter #(.WIDTH(4), .MOD(16), .SATURATE(1'b0)) dut_g (
        .clock(clk), .reset(rst[2]), .mode(md[2]), .load_val(ld_v[2]),
        .count(cnt[2]), .tc(tc[2]), .wrap(wrp[2])
`ifdef TFF_COUNTER_GRAY_EN
        , .count_gray(gray[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector mid-cycle, check tc, then compare the post-edge result from the scoreboard.
    task automatic step(input int sel, input vec_t v);
        exp_t e;
        @(negedge clk);
        rst[sel]  = v.r;
        md[sel]   = v.m;
        ld_v[sel] = v.ld;
        #1;
        check($sformatf("%s tc", v.tag), {31'd0, tc[sel]}, {31'd0, v.et});
        sbq.push_back('{sel, v.ec, v.ew, v.tag});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check($sformatf("%s count", e.tag), {28'd0, cnt[e.sel]}, {28'd0, e.ec});
        check($sformatf("%s wrap", e.tag), {31'd0, wrp[e.sel]}, {31'd0, e.ew});
`ifdef TFF_COUNTER_GRAY_EN
        check($sformatf("%s gray", e.tag), {28'd0, gray[e.sel]}, {28'd0, e.ec ^ (e.ec >> 1)});
`endif
    endtask

    function automatic vec_t mk(input logic r, input logic [1:0] m, input logic [3:0] ld,
                                input logic [3:0] ec, input logic ew, input logic et,
                                input string tag);
        vec_t v;
        v.r = r; v.m = m; v.ld = ld; v.ec = ec; v.ew = ew; v.et = et; v.tag = tag;
        return v;
    endfunction

    initial begin
        vec_t       ta[$];
        vec_t       tb[$];
        logic [3:0] prev_gray;

        for (int s = 0; s < 3; s++) begin
            rst[s] = 1'b1; md[s] = MODE_HOLD; ld_v[s] = 4'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset%0d count", s), {28'd0, cnt[s]}, 32'd0);
            check($sformatf("reset%0d wrap", s), {31'd0, wrp[s]}, 32'd0);
`ifdef TFF_COUNTER_GRAY_EN
            check($sformatf("reset%0d gray", s), {28'd0, gray[s]}, 32'd0);
`endif
        end
        @(negedge clk);
        for (int s = 0; s < 3; s++) rst[s] = 1'b0;

        // Wrapping MOD=10 counter.
        ta.push_back(mk(1, MODE_UP, 0, 0, 0, 0, "t1 rst"));
        for (int i = 0; i < 12; i++)
            ta.push_back(mk(0, MODE_UP, 0, 4'((i + 1) % 10), i == 9 ? 1'b1 : 1'b0,
                            i == 9 ? 1'b1 : 1'b0, $sformatf("t1 up%0d", i)));
        ta.push_back(mk(1, MODE_HOLD, 0, 0, 0, 0, "t2 rst"));
        ta.push_back(mk(0, MODE_DOWN, 0, 9, 1, 1, "t2 dn0"));
        ta.push_back(mk(0, MODE_DOWN, 0, 8, 0, 0, "t2 dn1"));
        ta.push_back(mk(0, MODE_LOAD, 7, 7, 0, 0, "t3 ld7"));
        ta.push_back(mk(0, MODE_UP, 0, 8, 0, 0, "t3 up0"));
        ta.push_back(mk(0, MODE_UP, 0, 9, 0, 0, "t3 up1"));
        ta.push_back(mk(0, MODE_UP, 0, 0, 1, 1, "t3 up2"));
        ta.push_back(mk(0, MODE_LOAD, 13, 9, 0, 0, "t3 ld13"));
        for (int i = 0; i < 5; i++)
            ta.push_back(mk(0, MODE_HOLD, 0, 9, 0, 0, $sformatf("t3 hold%0d", i)));
        ta.push_back(mk(0, MODE_LOAD, 5, 5, 0, 0, "t5 ld5"));
        ta.push_back(mk(0, MODE_UP, 0, 6, 0, 0, "t5 up"));
        ta.push_back(mk(1, MODE_UP, 0, 0, 0, 0, "t5 rst"));
        ta.push_back(mk(0, MODE_UP, 0, 1, 0, 0, "t5 resume0"));
        ta.push_back(mk(0, MODE_UP, 0, 2, 0, 0, "t5 resume1"));
        ta.push_back(mk(1, MODE_LOAD, 7, 0, 0, 0, "rst over load"));
        ta.push_back(mk(0, MODE_LOAD, 9, 9, 0, 0, "ld9"));
        ta.push_back(mk(1, MODE_UP, 0, 0, 0, 1, "rst over wrap"));
        ta.push_back(mk(0, MODE_HOLD, 0, 0, 0, 0, "hold after rst"));
        foreach (ta[i]) step(0, ta[i]);

        // Saturating MOD=10 counter.
        tb.push_back(mk(0, MODE_LOAD, 8, 8, 0, 0, "t4 ld8"));
        tb.push_back(mk(0, MODE_UP, 0, 9, 0, 0, "t4 up0"));
        for (int i = 1; i < 4; i++)
            tb.push_back(mk(0, MODE_UP, 0, 9, 0, 1, $sformatf("t4 up%0d", i)));
        tb.push_back(mk(0, MODE_LOAD, 1, 1, 0, 0, "t4 ld1"));
        tb.push_back(mk(0, MODE_DOWN, 0, 0, 0, 0, "t4 dn0"));
        tb.push_back(mk(0, MODE_DOWN, 0, 0, 0, 1, "t4 dn1"));
        tb.push_back(mk(0, MODE_LOAD, 15, 9, 0, 0, "t4 ld15"));
        tb.push_back(mk(0, MODE_HOLD, 0, 9, 0, 0, "t4 hold"));
        foreach (tb[i]) step(1, tb[i]);

        // Full-range MOD=16 counter: wrap at 15 without aliasing; Gray output one bit per step.
        prev_gray = 4'd0;
        for (int i = 0; i < 16; i++) begin
            step(2, mk(0, MODE_UP, 0, 4'((i + 1) % 16), i == 15 ? 1'b1 : 1'b0,
                       i == 15 ? 1'b1 : 1'b0, $sformatf("t6 up%0d", i)));
`ifdef TFF_COUNTER_GRAY_EN
            check($sformatf("t6 gray step%0d", i), $countones(gray[2] ^ prev_gray), 32'd1);
            if (i == 14) check("t6 gray at 15", {28'd0, gray[2]}, 32'h8);
            prev_gray = gray[2];
`endif
        end
        step(2, mk(0, MODE_DOWN, 0, 15, 1, 1, "m16 dn wrap"));
        step(2, mk(0, MODE_UP, 0, 0, 1, 1, "m16 up wrap"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
